// File: rtl/vga_tile_compositor.sv
`default_nettype none
// ============================================================================
//  Module   : vga_tile_compositor
//  Brief    : Composites NUM_TILES double-banked, writable image tiles onto a
//             640x480 VGA raster, with a tile-clear engine and frame-synchronous
//             bank switching.
//  Revision : 1.0 - initial release
// ============================================================================
module vga_tile_compositor #(
    parameter int                   COLOR_W     = 12,
    parameter int                   TILE_W      = 64,
    parameter int                   TILE_H      = 64,
    parameter int                   NUM_TILES   = 3,
    parameter int                   TILE_X0     = 192,
    parameter int                   TILE_STRIDE = 128,
    parameter int                   TILE_Y0     = 192,
    parameter logic [COLOR_W-1:0]   BG_COLOR    = 12'hDDD
) (
    input  logic                              CLK,
    input  logic                              RST,
    input  logic                              PIX_EN,
    input  logic [9:0]                        ADDRH,
    input  logic [8:0]                        ADDRV,
    input  logic                              REFRESH,
    input  logic [NUM_TILES-1:0]              BANK_SEL,
    input  logic                              WR_VALID,
    output logic                              WR_READY,
    input  logic [1:0]                        WR_TILE,
    input  logic                              WR_BANK,
    input  logic [$clog2(TILE_W*TILE_H)-1:0]  WR_ADDR,
    input  logic [COLOR_W-1:0]                WR_DATA,
    input  logic                              CLR_REQ,
    input  logic [1:0]                        CLR_TILE,
    output logic                              BUSY,
    output logic [COLOR_W-1:0]                PIX_COLOR
);

    localparam int c_DEPTH = TILE_W * TILE_H;
    localparam int c_AW    = $clog2(c_DEPTH);
    localparam int c_MAW   = $clog2(NUM_TILES * c_DEPTH);
    localparam logic [c_AW-1:0] c_LAST = c_AW'(c_DEPTH - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [c_AW-1:0]        r_cnt;
    logic [1:0]             r_clr_tile;
    logic [NUM_TILES-1:0]   r_active;

    // One array per bank so the clear engine can wipe both banks in one cycle
    logic [COLOR_W-1:0]     r_mem0 [NUM_TILES*c_DEPTH];
    logic [COLOR_W-1:0]     r_mem1 [NUM_TILES*c_DEPTH];

    logic                   w_vin;
    logic                   w_hit;
    logic [1:0]             w_tile;
    logic [c_AW-1:0]        w_idx;
    logic                   r_s1_hit;
    logic [1:0]             r_s1_tile;
    logic [c_AW-1:0]        r_s1_idx;
    logic                   w_rd_bank;
    logic [c_MAW-1:0]       w_rd_addr;
    logic [COLOR_W-1:0]     r_pix;

    logic                   w_wr_ok;
    logic                   w_clr_we;
    logic [c_MAW-1:0]       w_wr_addr;
    logic [c_MAW-1:0]       w_clr_addr;
    logic                   w_we0;
    logic                   w_we1;
    logic [c_MAW-1:0]       w_waddr;
    logic [COLOR_W-1:0]     w_wdata;

    // ------------------------------------------------------------------
    // Clear engine FSM
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (CLR_REQ) w_state_nxt = ST_CLEAR;
            ST_CLEAR: if (r_cnt == c_LAST) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_cnt      <= '0;
            r_clr_tile <= '0;
        end else if (r_state == ST_IDLE && CLR_REQ) begin
            r_clr_tile <= CLR_TILE;
            r_cnt      <= '0;
        end else if (r_state == ST_CLEAR) begin
            r_cnt      <= r_cnt + c_AW'(1);
        end
    end

    assign BUSY     = (r_state == ST_CLEAR);
    assign WR_READY = (r_state == ST_IDLE) && !CLR_REQ;

    // ------------------------------------------------------------------
    // Write path: host writes and clear writes never coincide because
    // WR_READY is low throughout a clear.
    // ------------------------------------------------------------------
    assign w_wr_ok    = WR_VALID && WR_READY && (32'(WR_TILE) < 32'(NUM_TILES));
    assign w_clr_we   = BUSY && (32'(r_clr_tile) < 32'(NUM_TILES));
    assign w_wr_addr  = c_MAW'(c_MAW'(WR_TILE) * c_MAW'(c_DEPTH) + c_MAW'(WR_ADDR));
    assign w_clr_addr = c_MAW'(c_MAW'(r_clr_tile) * c_MAW'(c_DEPTH) + c_MAW'(r_cnt));
    assign w_we0      = w_clr_we || (w_wr_ok && !WR_BANK);
    assign w_we1      = w_clr_we || (w_wr_ok &&  WR_BANK);
    assign w_waddr    = BUSY ? w_clr_addr : w_wr_addr;
    assign w_wdata    = BUSY ? BG_COLOR   : WR_DATA;

    always_ff @(posedge CLK) begin
        if (w_we0) r_mem0[w_waddr] <= w_wdata;
        if (w_we1) r_mem1[w_waddr] <= w_wdata;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_active <= '0;
        end else if (REFRESH) begin
            r_active <= BANK_SEL;
        end
    end

    // ------------------------------------------------------------------
    // Hit test: bounds are compared on the raw coordinates before any
    // subtraction, so out-of-range pixels cannot alias into a tile.
    // ------------------------------------------------------------------
    always_comb begin
        w_hit  = 1'b0;
        w_tile = '0;
        w_idx  = '0;
        w_vin  = (32'(ADDRV) >= 32'(TILE_Y0)) && (32'(ADDRV) < 32'(TILE_Y0 + TILE_H));
        for (int k = 0; k < NUM_TILES; k++) begin
            if (!w_hit && w_vin &&
                (32'(ADDRH) >= 32'(TILE_X0 + k*TILE_STRIDE)) &&
                (32'(ADDRH) <  32'(TILE_X0 + k*TILE_STRIDE + TILE_W))) begin
                w_hit  = 1'b1;
                w_tile = 2'(k);
                w_idx  = c_AW'((32'(ADDRV) - 32'(TILE_Y0)) * 32'(TILE_W)
                               + 32'(ADDRH) - 32'(TILE_X0 + k*TILE_STRIDE));
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_s1_hit  <= 1'b0;
            r_s1_tile <= '0;
            r_s1_idx  <= '0;
        end else if (PIX_EN) begin
            r_s1_hit  <= w_hit;
            r_s1_tile <= w_tile;
            r_s1_idx  <= w_idx;
        end
    end

    always_comb begin
        w_rd_bank = 1'b0;
        for (int k = 0; k < NUM_TILES; k++) begin
            if (2'(k) == r_s1_tile) w_rd_bank = r_active[k];
        end
    end

    assign w_rd_addr = c_MAW'(c_MAW'(r_s1_tile) * c_MAW'(c_DEPTH) + c_MAW'(r_s1_idx));

    // Synchronous read: a same-cycle write to this word yields the old data
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_pix <= BG_COLOR;
        end else if (PIX_EN) begin
            if (r_s1_hit) begin
                r_pix <= w_rd_bank ? r_mem1[w_rd_addr] : r_mem0[w_rd_addr];
            end else begin
                r_pix <= BG_COLOR;
            end
        end
    end

    assign PIX_COLOR = r_pix;

endmodule
`default_nettype wire

// File: tb/tb_vga_tile_compositor.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vga_tile_compositor
//  Brief    : Self-checking bench for vga_tile_compositor against a
//             behavioural frame-buffer model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_vga_tile_compositor;

    localparam logic [11:0] BG = 12'hDDD;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        PIX_EN = 1'b0;
    logic [9:0]  ADDRH = '0;
    logic [8:0]  ADDRV = '0;
    logic        REFRESH = 1'b0;
    logic [2:0]  BANK_SEL = '0;
    logic        WR_VALID = 1'b0;
    logic        WR_READY;
    logic [1:0]  WR_TILE = '0;
    logic        WR_BANK = 1'b0;
    logic [11:0] WR_ADDR = '0;
    logic [11:0] WR_DATA = '0;
    logic        CLR_REQ = 1'b0;
    logic [1:0]  CLR_TILE = '0;
    logic        BUSY;
    logic [11:0] PIX_COLOR;

    int checks = 0;
    int errors = 0;

    // Reference model: frame buffer per tile/bank plus displayed-bank flags
    logic [11:0] m_mem [0:2][0:1][0:4095];
    logic [2:0]  m_act = '0;

    vga_tile_compositor dut (
        .CLK(CLK), .RST(RST), .PIX_EN(PIX_EN), .ADDRH(ADDRH), .ADDRV(ADDRV),
        .REFRESH(REFRESH), .BANK_SEL(BANK_SEL), .WR_VALID(WR_VALID),
        .WR_READY(WR_READY), .WR_TILE(WR_TILE), .WR_BANK(WR_BANK),
        .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA), .CLR_REQ(CLR_REQ),
        .CLR_TILE(CLR_TILE), .BUSY(BUSY), .PIX_COLOR(PIX_COLOR)
    );

    always #5 CLK = ~CLK;

    initial begin
        #3_000_000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    function automatic logic [11:0] exp_pix(input int h, input int v);
        logic [11:0] c;
        int x0;
        c = BG;
        for (int k = 0; k < 3; k++) begin
            x0 = 192 + 128 * k;
            if (h >= x0 && h < x0 + 64 && v >= 192 && v < 256)
                c = m_mem[k][m_act[k]][(v - 192) * 64 + (h - x0)];
        end
        return c;
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic model_clear(input int t);
        if (t < 3)
            for (int b = 0; b < 2; b++)
                for (int a = 0; a < 4096; a++) m_mem[t][b][a] = BG;
    endtask

    task automatic do_write(input int t, input int b, input int a, input logic [11:0] d);
        WR_VALID = 1'b1; WR_TILE = 2'(t); WR_BANK = b[0]; WR_ADDR = 12'(a); WR_DATA = d;
        tick();
        WR_VALID = 1'b0;
        if (t < 3) m_mem[t][b][a] = d;
    endtask

    task automatic read_px(input int h, input int v, output logic [11:0] c);
        ADDRH = 10'(h); ADDRV = 9'(v); PIX_EN = 1'b1;
        tick();
        tick();
        PIX_EN = 1'b0;
        c = PIX_COLOR;
    endtask

    task automatic start_clear(input int t);
        CLR_REQ = 1'b1; CLR_TILE = 2'(t);
        tick();
        CLR_REQ = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        tick(); tick();
        checks++; if (PIX_COLOR !== BG) begin errors++; $display("FAIL reset_pix got %h exp %h", PIX_COLOR, BG); end
        checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", BUSY); end
        checks++; if (WR_READY !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", WR_READY); end
        RST = 1'b0;
    endtask

    task automatic test_init_clear();
        int n;
        for (int t = 0; t < 3; t++) begin
            start_clear(t);
            n = 0;
            while (BUSY && n < 10000) begin tick(); n++; end
            model_clear(t);
            checks++; if (n != 4096) begin errors++; $display("FAIL init_clear_len tile=%0d got %0d exp 4096", t, n); end
        end
    endtask

    task automatic test_write_read();
        logic [11:0] c;
        do_write(0, 0, 65, 12'hF00);
        read_px(193, 193, c);
        checks++; if (c !== 12'hF00) begin errors++; $display("FAIL write_read got %h exp f00", c); end
    endtask

    task automatic test_bank_switch();
        logic [11:0] c;
        do_write(0, 1, 65, 12'h0F0);
        BANK_SEL = 3'b001;
        read_px(193, 193, c);
        checks++; if (c !== 12'hF00) begin errors++; $display("FAIL bank_no_refresh got %h exp f00", c); end
        REFRESH = 1'b1; tick(); REFRESH = 1'b0;
        m_act = BANK_SEL;
        read_px(193, 193, c);
        checks++; if (c !== 12'h0F0) begin errors++; $display("FAIL bank_after_refresh got %h exp 0f0", c); end
        BANK_SEL = 3'b000;
        read_px(193, 193, c);
        checks++; if (c !== 12'h0F0) begin errors++; $display("FAIL bank_hold got %h exp 0f0", c); end
    endtask

    task automatic test_clear();
        int n, bad_rdy, bad_px;
        logic [11:0] c;
        for (int i = 0; i < 8; i++) do_write(2, i % 2, $urandom_range(0, 4095), 12'($urandom));
        do_write(2, 0, 0, 12'h123);
        start_clear(2);
        n = 0; bad_rdy = 0;
        while (BUSY && n < 10000) begin
            if (WR_READY !== 1'b0) bad_rdy++;
            // A write and a second clear request during the clear must both be ignored
            WR_VALID = (n == 10); WR_TILE = 2'd0; WR_BANK = m_act[0]; WR_ADDR = 12'd65; WR_DATA = 12'h123;
            CLR_REQ = (n == 20); CLR_TILE = 2'd0;
            tick(); n++;
        end
        WR_VALID = 1'b0; CLR_REQ = 1'b0;
        model_clear(2);
        checks++; if (n != 4096) begin errors++; $display("FAIL clear_len got %0d exp 4096", n); end
        checks++; if (bad_rdy != 0) begin errors++; $display("FAIL clear_ready_low bad_cycles=%0d exp 0", bad_rdy); end
        bad_px = 0;
        for (int v = 192; v < 256; v++)
            for (int h = 448; h < 512; h++) begin
                read_px(h, v, c);
                if (c !== BG) bad_px++;
            end
        checks++; if (bad_px != 0) begin errors++; $display("FAIL clear_tile2_bg bad_pixels=%0d exp 0", bad_px); end
        read_px(193, 193, c);
        checks++; if (c !== exp_pix(193, 193)) begin errors++; $display("FAIL clear_tile0_intact got %h exp %h", c, exp_pix(193, 193)); end
    endtask

    task automatic test_edges();
        logic [11:0] c;
        int hs[8] = '{255, 256, 255, 639, 192, 191, 192, 320};
        int vs[8] = '{255, 255, 256, 479, 192, 192, 191, 192};
        do_write(0, m_act[0], 4095, 12'h5A5);
        do_write(0, m_act[0], 0, 12'hA5A);
        do_write(1, m_act[1], 0, 12'h3C3);
        for (int i = 0; i < 8; i++) begin
            read_px(hs[i], vs[i], c);
            checks++;
            if (c !== exp_pix(hs[i], vs[i])) begin
                errors++; $display("FAIL edge h=%0d v=%0d got %h exp %h", hs[i], vs[i], c, exp_pix(hs[i], vs[i]));
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [11:0] c;
        logic [11:0] d [8];
        for (int i = 0; i < 8; i++) d[i] = 12'($urandom);
        WR_VALID = 1'b1; WR_TILE = 2'd1; WR_BANK = m_act[1];
        for (int i = 0; i < 8; i++) begin
            WR_ADDR = 12'(i); WR_DATA = d[i];
            tick();
            m_mem[1][m_act[1]][i] = d[i];
        end
        WR_VALID = 1'b0;
        for (int i = 0; i < 8; i++) begin
            read_px(320 + i, 192, c);
            checks++; if (c !== d[i]) begin errors++; $display("FAIL b2b idx=%0d got %h exp %h", i, c, d[i]); end
        end
    endtask

    task automatic test_collision();
        logic [11:0] oldv, newv, c;
        oldv = exp_pix(193, 193);
        newv = ~oldv;
        ADDRH = 10'd193; ADDRV = 9'd193; PIX_EN = 1'b1;
        tick();
        WR_VALID = 1'b1; WR_TILE = 2'd0; WR_BANK = m_act[0]; WR_ADDR = 12'd65; WR_DATA = newv;
        tick();
        WR_VALID = 1'b0; PIX_EN = 1'b0;
        m_mem[0][m_act[0]][65] = newv;
        checks++; if (PIX_COLOR !== oldv) begin errors++; $display("FAIL collision_old got %h exp %h", PIX_COLOR, oldv); end
        read_px(193, 193, c);
        checks++; if (c !== newv) begin errors++; $display("FAIL collision_new got %h exp %h", c, newv); end
    endtask

    task automatic test_random();
        logic [11:0] c, e;
        int op, t, b, a, h, v, lt, la, bad;
        lt = 0; la = 65; bad = 0;
        for (int it = 0; it < 300; it++) begin
            op = $urandom_range(0, 9);
            if (op < 4) begin
                t = $urandom_range(0, 3); b = $urandom_range(0, 1); a = $urandom_range(0, 4095);
                do_write(t, b, a, 12'($urandom));
                if (t < 3) begin lt = t; la = a; end
            end else if (op < 9) begin
                if ($urandom_range(0, 1) == 1) begin
                    h = 192 + 128 * lt + la % 64; v = 192 + la / 64;
                end else begin
                    h = $urandom_range(0, 639); v = $urandom_range(180, 270);
                end
                read_px(h, v, c);
                e = exp_pix(h, v);
                checks++;
                if (c !== e) begin
                    errors++; bad++;
                    if (bad < 10) $display("FAIL random_px h=%0d v=%0d got %h exp %h", h, v, c, e);
                end
            end else begin
                BANK_SEL = 3'($urandom);
                REFRESH = 1'b1; tick(); REFRESH = 1'b0;
                m_act = BANK_SEL;
            end
        end
    endtask

    task automatic test_reset_mid_clear();
        int n;
        logic [11:0] c, e;
        start_clear(1);
        for (int i = 0; i < 100; i++) tick();
        RST = 1'b1; tick(); RST = 1'b0;
        m_act = '0;
        checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL midclr_busy got %b exp 0", BUSY); end
        checks++; if (WR_READY !== 1'b1) begin errors++; $display("FAIL midclr_ready got %b exp 1", WR_READY); end
        checks++; if (PIX_COLOR !== BG) begin errors++; $display("FAIL midclr_pix got %h exp %h", PIX_COLOR, BG); end
        start_clear(1);
        n = 0;
        while (BUSY && n < 10000) begin tick(); n++; end
        model_clear(1);
        checks++; if (n != 4096) begin errors++; $display("FAIL reclear_len got %0d exp 4096", n); end
        // Clear and write in the same idle cycle: the write must be dropped
        e = exp_pix(193, 193);
        WR_VALID = 1'b1; WR_TILE = 2'd0; WR_BANK = m_act[0]; WR_ADDR = 12'd65; WR_DATA = ~e;
        CLR_REQ = 1'b1; CLR_TILE = 2'd3;
        #1;
        checks++; if (WR_READY !== 1'b0) begin errors++; $display("FAIL clr_wr_ready got %b exp 0", WR_READY); end
        tick();
        WR_VALID = 1'b0; CLR_REQ = 1'b0;
        checks++; if (BUSY !== 1'b1) begin errors++; $display("FAIL clr3_busy got %b exp 1", BUSY); end
        n = 0;
        while (BUSY && n < 10000) begin tick(); n++; end
        checks++; if (n != 4096) begin errors++; $display("FAIL clr3_len got %0d exp 4096", n); end
        read_px(193, 193, c);
        checks++; if (c !== e) begin errors++; $display("FAIL clr_wr_dropped got %h exp %h", c, e); end
        read_px(448, 192, c);
        checks++; if (c !== exp_pix(448, 192)) begin errors++; $display("FAIL clr3_no_ram got %h exp %h", c, exp_pix(448, 192)); end
    endtask

    initial begin
        test_reset();
        test_init_clear();
        test_write_read();
        test_bank_switch();
        test_clear();
        test_edges();
        test_back_to_back();
        test_collision();
        test_random();
        test_reset_mid_clear();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
